// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with an autonomous, maskable scan mode.
// Define SCAN_DECODER_BLANK_EN to add BLANK_CYC cycles of dead time after each scan advance.
module scan_decoder #(
  parameter int SEL_W     = 2,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        a,
  input  logic [(1<<SEL_W)-1:0]   ch_mask,
  output logic [(1<<SEL_W)-1:0]   bcode,
  output logic [SEL_W-1:0]        sel,
  output logic                    tick
);

  localparam int N_OUT = 1 << SEL_W;
  localparam int CNT_W = $clog2(PRESCALE);

  if (PRESCALE < 2 || BLANK_CYC < 1 || BLANK_CYC >= PRESCALE) begin : g_param_check
    $error("scan_decoder: PRESCALE must be >= 2 and BLANK_CYC in 1..PRESCALE-1");
  end

  // Scans upward from 'from' (starting at offset first_off) for the first set
  // mask bit, wrapping around; returns 'from' unchanged when the mask is empty.
  function automatic logic [SEL_W-1:0] find_set(input logic [SEL_W-1:0] from,
                                                input logic [N_OUT-1:0] mask,
                                                input int               first_off);
    logic [SEL_W-1:0] idx;
    logic             found;
    find_set = from;
    found    = 1'b0;
    for (int k = 0; k <= N_OUT; k++) begin
      idx = from + SEL_W'(k);
      if (!found && k >= first_off && mask[idx]) begin
        find_set = idx;
        found    = 1'b1;
      end
    end
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             mode_prev;
  logic             entry;
  logic             wrap;
  logic             advance;
  logic [SEL_W-1:0] sel_next;
  logic [N_OUT-1:0] hot_next;

  always_comb begin
    entry    = mode && !mode_prev;
    wrap     = (cnt == CNT_W'(PRESCALE - 1));
    advance  = mode && !entry && wrap;
    sel_next = sel;
    if (!mode)
      sel_next = a;
    else if (entry)
      sel_next = find_set(sel, ch_mask, 0);
    else if (wrap)
      sel_next = find_set(sel, ch_mask, 1);
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_hot
    assign hot_next[gi] = (sel_next == SEL_W'(gi));
  end

`ifdef SCAN_DECODER_BLANK_EN
  localparam int BLANK_W = $clog2(BLANK_CYC + 1);
  logic [BLANK_W-1:0] blank;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bcode     <= '0;
      sel       <= '0;
      tick      <= 1'b0;
      cnt       <= '0;
      // Track the live mode so a reset held in scan mode does not look like a mode entry.
      mode_prev <= mode;
`ifdef SCAN_DECODER_BLANK_EN
      blank     <= '0;
`endif
    end else if (en) begin
      mode_prev <= mode;
      sel       <= sel_next;
      tick      <= advance;
      cnt       <= (!mode || entry || wrap) ? '0 : cnt + CNT_W'(1);
`ifdef SCAN_DECODER_BLANK_EN
      if (!mode)
        blank <= '0;
      else if (advance)
        blank <= BLANK_W'(BLANK_CYC - 1);
      else if (blank != '0)
        blank <= blank - BLANK_W'(1);
      bcode <= (mode && (advance || blank != '0)) ? '0 : (hot_next & ch_mask);
`else
      bcode <= hot_next & ch_mask;
`endif
    end else begin
      bcode <= '0;
      tick  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder (SEL_W=2, PRESCALE=4, BLANK_CYC=1).
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       mode;
  logic [1:0] a;
  logic [3:0] ch_mask;
  logic [3:0] bcode;
  logic [1:0] sel;
  logic       tick;

  int tests = 0;
  int fails = 0;
  int seq_tab [4] = '{0, 2, 3, 0};

`ifdef SCAN_DECODER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  scan_decoder #(.SEL_W(2), .PRESCALE(4), .BLANK_CYC(1)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .a(a),
    .ch_mask(ch_mask), .bcode(bcode), .sel(sel), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected scan-mode bcode: one-hot of sel masked, blanked on tick cycles when enabled.
  function automatic logic [3:0] exp_scan(input int s, input logic [3:0] m, input bit t);
    logic [3:0] h;
    h = 4'b0001 << s;
    if (BLANK && t) return 4'b0000;
    return h & m;
  endfunction

  initial begin
    int s;
    bit t;
    logic [3:0] h;

    reset_n = 1'b0; en = 1'b1; mode = 1'b1; a = 2'd0; ch_mask = 4'hF;
    repeat (3) @(posedge clk);
    step();
    chk("rst_bcode", 32'(bcode), 32'h0);
    chk("rst_sel",   32'(sel),   32'h0);
    chk("rst_tick",  32'(tick),  32'h0);
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      t = (i == 4);
      s = t ? 1 : 0;
      chk("rel_tick",  32'(tick),  32'(t));
      chk("rel_sel",   32'(sel),   32'(s));
      chk("rel_bcode", 32'(bcode), 32'(exp_scan(s, 4'hF, t)));
    end

    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      step();
      h = 4'b0001 << i;
      chk("dir_bcode", 32'(bcode), 32'(h));
      chk("dir_sel",   32'(sel),   32'(i));
      chk("dir_tick",  32'(tick),  32'h0);
    end
    ch_mask = 4'b1011; a = 2'd2;
    step();
    chk("dir_masked_bcode", 32'(bcode), 32'h0);
    chk("dir_masked_sel",   32'(sel),   32'h2);

    a = 2'd0; ch_mask = 4'b1101;
    step();
    chk("dir_a0_bcode", 32'(bcode), 32'h1);

    mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      s = seq_tab[i / 4];
      t = (i % 4 == 0) && (i > 0);
      chk("scan_sel",   32'(sel),   32'(s));
      chk("scan_tick",  32'(tick),  32'(t));
      chk("scan_bcode", 32'(bcode), 32'(exp_scan(s, 4'b1101, t)));
    end

    ch_mask = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step();
      t = (i % 4 == 0);
      chk("zmask_tick",  32'(tick),  32'(t));
      chk("zmask_sel",   32'(sel),   32'h0);
      chk("zmask_bcode", 32'(bcode), 32'h0);
    end

    ch_mask = 4'hF;
    step();
    chk("pre_frz_tick",  32'(tick),  32'h1);
    chk("pre_frz_sel",   32'(sel),   32'h1);
    chk("pre_frz_bcode", 32'(bcode), 32'(exp_scan(1, 4'hF, 1'b1)));
    step();
    chk("mid_dwell_bcode", 32'(bcode), 32'h2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frz_bcode", 32'(bcode), 32'h0);
      chk("frz_tick",  32'(tick),  32'h0);
      chk("frz_sel",   32'(sel),   32'h1);
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      t = (i == 3);
      s = t ? 2 : 1;
      chk("resume_tick",  32'(tick),  32'(t));
      chk("resume_sel",   32'(sel),   32'(s));
      chk("resume_bcode", 32'(bcode), 32'(exp_scan(s, 4'hF, t)));
    end

    mode = 1'b0; a = 2'd3;
    step();
    chk("msw_dir_sel",   32'(sel),   32'h3);
    chk("msw_dir_bcode", 32'(bcode), 32'h8);
    mode = 1'b1; ch_mask = 4'b0011;
    step();
    chk("msw_entry_sel",   32'(sel),   32'h0);
    chk("msw_entry_bcode", 32'(bcode), 32'h1);
    chk("msw_entry_tick",  32'(tick),  32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      t = (i == 4);
      s = t ? 1 : 0;
      chk("msw_tick",  32'(tick),  32'(t));
      chk("msw_sel",   32'(sel),   32'(s));
      chk("msw_bcode", 32'(bcode), 32'(exp_scan(s, 4'b0011, t)));
    end

    reset_n = 1'b0;
    step();
    chk("rst2_bcode", 32'(bcode), 32'h0);
    chk("rst2_sel",   32'(sel),   32'h0);
    chk("rst2_tick",  32'(tick),  32'h0);
    reset_n = 1'b1; ch_mask = 4'hF;
    step();
    chk("rst2_rel_sel",   32'(sel),   32'h0);
    chk("rst2_rel_bcode", 32'(bcode), 32'h1);
    chk("rst2_rel_tick",  32'(tick),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
